// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and leading-zero blank mask for the seven-segment display blocks
package sseg_pkg;
    localparam int SSEG_NUM_DIGITS = 4;
    localparam int DIGIT_W = 4;
    localparam int MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // bit i set when digit i is nonzero-indexed and nibbles i..n_digits-1 are all zero
    function automatic logic [MAX_DIGITS-1:0] blank_mask(
        input logic [DIGIT_W*MAX_DIGITS-1:0] shadow,
        input int n_digits
    );
        logic zero_run;
        blank_mask = '0;
        zero_run = 1'b1;
        for (int i = MAX_DIGITS - 1; i > 0; i--) begin
            if (i < n_digits) begin
                zero_run = zero_run && (shadow[DIGIT_W*i +: DIGIT_W] == '0);
                blank_mask[i] = zero_run;
            end
        end
    endfunction
endpackage

// File: rtl/sseg_digit_scan_if.sv
// sseg_digit_scan_if: data/control inputs and scan outputs of the digit scanner
interface sseg_digit_scan_if #(parameter int N_DIGITS = sseg_pkg::SSEG_NUM_DIGITS);
    import sseg_pkg::*;
    localparam int IDX_W = $clog2(N_DIGITS);
    logic [DIGIT_W*N_DIGITS-1:0] data_in;
    logic                        load;
    logic                        en;
    logic                        blank_lz;
    logic [DIGIT_W-1:0]          bcd_out;
    logic [N_DIGITS-1:0]         an_n;
    logic [IDX_W-1:0]            digit_idx;

    modport master (
        output data_in, load, en, blank_lz,
        input  bcd_out, an_n, digit_idx
    );

    modport slave (
        input  data_in, load, en, blank_lz,
        output bcd_out, an_n, digit_idx
    );
endinterface

// File: rtl/sseg_tick_gen.sv
// sseg_tick_gen: free-running prescaler, one-cycle tick every TICK_DIV clocks
module sseg_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/sseg_digit_scan.sv
// sseg_digit_scan: multiplexed common-anode scanner feeding one nibble per digit to the decoder
module sseg_digit_scan
    import sseg_pkg::*;
#(
    parameter int N_DIGITS = SSEG_NUM_DIGITS,
    parameter int TICK_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    sseg_digit_scan_if.slave   bus
);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int SH_W  = DIGIT_W * N_DIGITS;

    logic                  w_tick;
    logic [MAX_DIGITS-1:0] w_mask;
    logic                  w_dark;
    logic [SH_W-1:0]       r_shadow;
    logic [IDX_W-1:0]      r_idx;
    logic [DIGIT_W-1:0]    r_bcd;
    logic [N_DIGITS-1:0]   r_an;

    sseg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    always_comb begin
        w_mask = blank_mask((DIGIT_W*MAX_DIGITS)'(r_shadow), N_DIGITS);
        w_dark = !bus.en || (bus.blank_lz && w_mask[r_idx]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_idx    <= '0;
        end else begin
            if (bus.load) r_shadow <= bus.data_in;
            if (w_tick)   r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    // outputs lag shadow/index by one cycle, so an_n trails digit_idx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_an  <= AN_OFF[N_DIGITS-1:0];
        end else begin
            r_bcd <= r_shadow[DIGIT_W*r_idx +: DIGIT_W];
            r_an  <= w_dark ? AN_OFF[N_DIGITS-1:0] : ~(N_DIGITS'(1) << r_idx);
        end
    end

    assign bus.bcd_out   = r_bcd;
    assign bus.an_n      = r_an;
    assign bus.digit_idx = r_idx;
endmodule
